// File: rtl/psum_acc_buf.sv
// -----------------------------------------------------------------------------
// psum_acc_buf
//
// Output-stationary partial-sum accumulation buffer for the PE array.
// Accepts one col-lane psum vector per cycle and adds it, read-modify-write,
// into a depth-entry register store. A programmable window of entries can be
// drained over a valid/ready stream, with optional ReLU and clear-on-read.
//
// Accumulate pipeline: S1 (accepted request) -> S2 (request + read value) ->
// store write. A request accepted at edge N lands in the store at edge N+2.
// Back-to-back requests to the same entry are forwarded from S2 to S1.
//
// Build option:
//   PSUM_ACC_SAT_EN  defined   : lane adds saturate to the signed range.
//                    undefined : lane adds wrap (two's complement).
//   Overwrite requests (acc_first) are never saturated.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous reset, active low
//   acc_valid    accumulate request valid
//   acc_ready    accumulate request ready (high in IDLE only)
//   acc_first    1: overwrite entry with acc_data, 0: add acc_data to entry
//   acc_addr     target entry
//   acc_data     psum vector, lane i at [i*psum_bw +: psum_bw]
//   drain_start  drain request pulse, sampled in IDLE only
//   drain_base   first entry to drain
//   drain_len    number of entries to drain (0 is ignored)
//   drain_relu   clamp negative lanes to 0 on output (captured at start)
//   drain_clr    zero each entry after its handshake (captured at start)
//   out_valid    drain stream valid
//   out_ready    drain stream ready
//   out_last     marks the final drained entry
//   out_data     drained entry
//   done         one-cycle pulse after the final drain handshake
//   busy         FSM not idle or accumulate pipeline not empty
// -----------------------------------------------------------------------------
module psum_acc_buf #(
  parameter int col      = 8,
  parameter int psum_bw  = 16,
  parameter int depth    = 64,
  localparam int aw      = $clog2(depth),
  localparam int dw      = psum_bw * col
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          acc_valid,
  output logic          acc_ready,
  input  logic          acc_first,
  input  logic [aw-1:0] acc_addr,
  input  logic [dw-1:0] acc_data,
  input  logic          drain_start,
  input  logic [aw-1:0] drain_base,
  input  logic [aw:0]   drain_len,
  input  logic          drain_relu,
  input  logic          drain_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [dw-1:0] out_data,
  output logic          done,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Accumulate pipeline stage 1
  logic          s1_valid_q, s1_valid_d;
  logic          s1_first_q, s1_first_d;
  logic [aw-1:0] s1_addr_q,  s1_addr_d;
  logic [dw-1:0] s1_data_q,  s1_data_d;

  // Accumulate pipeline stage 2 (carries the old entry value)
  logic          s2_valid_q, s2_valid_d;
  logic          s2_first_q, s2_first_d;
  logic [aw-1:0] s2_addr_q,  s2_addr_d;
  logic [dw-1:0] s2_data_q,  s2_data_d;
  logic [dw-1:0] s2_rd_q,    s2_rd_d;

  // Psum store
  logic [dw-1:0] store_q [depth];
  logic [dw-1:0] store_d [depth];

  // Drain context
  logic [aw-1:0] ptr_q,  ptr_d;
  logic [aw:0]   cnt_q,  cnt_d;   // entries still to hand over
  logic          relu_q, relu_d;
  logic          clr_q,  clr_d;
  logic          done_q, done_d;

  logic [dw-1:0] wr_val;     // value S2 writes into the store this cycle
  logic [dw-1:0] rd_entry;   // entry under the drain pointer
  logic [dw-1:0] relu_data;  // rd_entry after optional ReLU
  logic          pipe_empty;
  logic          drain_fire;
  logic          drain_hs;
  logic          drain_end;

  assign pipe_empty = !s1_valid_q && !s2_valid_q;
  assign drain_fire = (state_q == ST_IDLE) && drain_start && (drain_len != '0);
  assign drain_hs   = out_valid && out_ready;
  assign drain_end  = drain_hs && (cnt_q == (aw+1)'(1));
  assign rd_entry   = store_q[ptr_q];

`ifdef PSUM_ACC_SAT_EN
  localparam logic [psum_bw-1:0] sat_max = {1'b0, {(psum_bw-1){1'b1}}};
  localparam logic [psum_bw-1:0] sat_min = {1'b1, {(psum_bw-1){1'b0}}};
`endif

  // ---------------------------------------------------------------------------
  // Per-lane arithmetic: S2 write value and drain-side ReLU
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < col; gi++) begin : g_lane
      logic [psum_bw-1:0] old_l;
      logic [psum_bw-1:0] add_l;
      logic [psum_bw-1:0] sum_l;
      logic [psum_bw-1:0] rd_l;

      assign old_l = s2_rd_q[gi*psum_bw +: psum_bw];
      assign add_l = s2_data_q[gi*psum_bw +: psum_bw];

`ifdef PSUM_ACC_SAT_EN
      // One extra bit catches overflow: the two top bits of the sign-extended
      // sum differ exactly when the result left the signed range, and the
      // extended sign tells which rail to clamp to.
      logic [psum_bw:0] sum_ext;
      assign sum_ext = {old_l[psum_bw-1], old_l} + {add_l[psum_bw-1], add_l};
      assign sum_l   = (sum_ext[psum_bw] ^ sum_ext[psum_bw-1])
                     ? (sum_ext[psum_bw] ? sat_min : sat_max)
                     : sum_ext[psum_bw-1:0];
`else
      assign sum_l = old_l + add_l;
`endif

      assign wr_val[gi*psum_bw +: psum_bw] = s2_first_q ? add_l : sum_l;

      assign rd_l = rd_entry[gi*psum_bw +: psum_bw];
      assign relu_data[gi*psum_bw +: psum_bw] =
        (relu_q && rd_l[psum_bw-1]) ? '0 : rd_l;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (drain_fire) state_d = ST_FLUSH;
      // Wait for in-flight accumulates to land before reading the store.
      ST_FLUSH: if (pipe_empty) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_end)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    acc_ready = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        acc_ready = 1'b1;
        busy      = !pipe_empty;
      end
      ST_DRAIN: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign out_last = out_valid && (cnt_q == (aw+1)'(1));
  assign out_data = out_valid ? relu_data : '0;
  assign done     = done_q;

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_valid_d = acc_valid && acc_ready;
    s1_first_d = acc_first;
    s1_addr_d  = acc_addr;
    s1_data_d  = acc_data;

    s2_valid_d = s1_valid_q;
    s2_first_d = s1_first_q;
    s2_addr_d  = s1_addr_q;
    s2_data_d  = s1_data_q;
    // S2 writes the same entry on this edge, so the store copy is stale.
    if (s2_valid_q && (s2_addr_q == s1_addr_q)) begin
      s2_rd_d = wr_val;
    end else begin
      s2_rd_d = store_q[s1_addr_q];
    end

    // Accumulate writes and drain clears never coincide: acc_ready is low
    // outside IDLE and the drain only starts once the pipeline is empty.
    store_d = store_q;
    if (s2_valid_q) begin
      store_d[s2_addr_q] = wr_val;
    end
    if (drain_hs && clr_q) begin
      store_d[ptr_q] = '0;
    end

    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    relu_d = relu_q;
    clr_d  = clr_q;
    if (drain_fire) begin
      ptr_d  = drain_base;
      cnt_d  = drain_len;
      relu_d = drain_relu;
      clr_d  = drain_clr;
    end else if (drain_hs) begin
      ptr_d = ptr_q + aw'(1);   // wraps modulo depth
      cnt_d = cnt_q - (aw+1)'(1);
    end

    done_d = drain_end;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_data_q  <= '0;
      s2_rd_q    <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      relu_q     <= 1'b0;
      clr_q      <= 1'b0;
      done_q     <= 1'b0;
      for (int i = 0; i < depth; i++) begin
        store_q[i] <= '0;
      end
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_addr_q  <= s1_addr_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_first_q <= s2_first_d;
      s2_addr_q  <= s2_addr_d;
      s2_data_q  <= s2_data_d;
      s2_rd_q    <= s2_rd_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      relu_q     <= relu_d;
      clr_q      <= clr_d;
      done_q     <= done_d;
      for (int i = 0; i < depth; i++) begin
        store_q[i] <= store_d[i];
      end
    end
  end

endmodule

// File: tb/tb_psum_acc_buf.sv
// -----------------------------------------------------------------------------
// tb_psum_acc_buf
//
// Scoreboard bench for psum_acc_buf. The reference model keeps every entry as
// plain integer lanes and applies accumulates the moment they are accepted;
// each drain pushes the expected output words into a queue, and an
// independent monitor pops and compares on every output handshake.
// -----------------------------------------------------------------------------
module tb_psum_acc_buf;

  localparam int COL   = 8;
  localparam int PBW   = 16;
  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int W     = COL * PBW;
  localparam int LMAX  = (1 << (PBW - 1)) - 1;
  localparam int LMIN  = -(1 << (PBW - 1));

  logic          clk = 1'b0;
  logic          reset;
  logic          acc_valid;
  logic          acc_ready;
  logic          acc_first;
  logic [AW-1:0] acc_addr;
  logic [W-1:0]  acc_data;
  logic          drain_start;
  logic [AW-1:0] drain_base;
  logic [AW:0]   drain_len;
  logic          drain_relu;
  logic          drain_clr;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic [W-1:0]  out_data;
  logic          done;
  logic          busy;

  psum_acc_buf #(.col(COL), .psum_bw(PBW), .depth(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .acc_valid   (acc_valid),
    .acc_ready   (acc_ready),
    .acc_first   (acc_first),
    .acc_addr    (acc_addr),
    .acc_data    (acc_data),
    .drain_start (drain_start),
    .drain_base  (drain_base),
    .drain_len   (drain_len),
    .drain_relu  (drain_relu),
    .drain_clr   (drain_clr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .out_data    (out_data),
    .done        (done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  exp_t exp_q[$];
  int   mm [DEPTH][COL];   // reference store, one int per lane
  int   lv [COL];          // lane values for the next request
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void chk(string name, logic [W-1:0] act, logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endfunction

  function automatic int fix_lane(int s);
`ifdef PSUM_ACC_SAT_EN
    if (s > LMAX) return LMAX;
    if (s < LMIN) return LMIN;
    return s;
`else
    if (s > LMAX) return s - (1 << PBW);
    if (s < LMIN) return s + (1 << PBW);
    return s;
`endif
  endfunction

  function automatic logic [W-1:0] pack_lv();
    logic [W-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < COL; i++) begin
      v = lv[i];
      r[i*PBW +: PBW] = v[PBW-1:0];
    end
    return r;
  endfunction

  function automatic void model_acc(logic first, logic [AW-1:0] addr, logic [W-1:0] data);
    int d;
    for (int i = 0; i < COL; i++) begin
      d = int'($signed(data[i*PBW +: PBW]));
      mm[addr][i] = first ? d : fix_lane(mm[addr][i] + d);
    end
  endfunction

  function automatic logic [W-1:0] model_entry(int a, logic relu);
    logic [W-1:0] r;
    int v;
    r = '0;
    for (int i = 0; i < COL; i++) begin
      v = mm[a][i];
      if (relu && v < 0) v = 0;
      r[i*PBW +: PBW] = v[PBW-1:0];
    end
    return r;
  endfunction

  function automatic logic rdy_pat(int mode, int idx);
    case (mode)
      1:       return (idx % 2) == 0;
      2:       return 1'($urandom_range(0, 1));
      4:       return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  task automatic set_all(input int v);
    for (int i = 0; i < COL; i++) lv[i] = v;
  endtask

  task automatic set_acc(input logic first, input int addr);
    acc_valid = 1'b1;
    acc_first = first;
    acc_addr  = addr[AW-1:0];
    acc_data  = pack_lv();
  endtask

  // Issue one accumulate; returns at posedge+1 after acceptance with
  // acc_valid still asserted so calls chain back-to-back.
  task automatic do_acc(input logic first, input int addr);
    logic ok;
    set_acc(first, addr);
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      ok = acc_ready;
      @(posedge clk);
      #1;
      if (ok) begin
        model_acc(first, addr[AW-1:0], acc_data);
        return;
      end
    end
    n_checks++;
    n_fail++;
    $display("FAIL acc_accept_timeout: actual acc_ready=0 required 1");
  endtask

  // Stop issuing and watch the pipeline empty after the last accepted request.
  task automatic acc_stop();
    acc_valid = 1'b0;
    @(negedge clk);
    chk("busy_s1", busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_s2", busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_empty", busy, 0);
    @(posedge clk); #1;
  endtask

  // mode: 0 ready always, 1 toggle 1/0, 2 random, 4 one handshake then stall.
  // exp_lat: cycles from the start edge to the first out_valid (0 = unchecked).
  task automatic drain(input int base, input int len, input logic relu, input logic clr,
                       input int mode, input logic with_acc, input int exp_lat);
    logic ok;
    int   lat;
    int   idx;
    logic got_done;
    int   a;
    exp_t e;
    if (!with_acc) acc_valid = 1'b0;
    drain_start = 1'b1;
    drain_base  = base[AW-1:0];
    drain_len   = len[AW:0];
    drain_relu  = relu;
    drain_clr   = clr;
    out_ready   = 1'b1;
    @(negedge clk);
    ok = acc_ready;
    chk("idle_before_drain", ok, 1);
    @(posedge clk); #1;
    drain_start = 1'b0;
    if (with_acc && acc_valid && ok) model_acc(acc_first, acc_addr, acc_data);
    acc_valid = 1'b0;

    if (len == 0) begin
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        chk("len0_out_valid", out_valid, 0);
        chk("len0_acc_ready", acc_ready, 1);
        @(posedge clk); #1;
      end
      return;
    end

    for (int i = 0; i < len; i++) begin
      a = (base + i) % DEPTH;
      e.data = model_entry(a, relu);
      e.last = (i == len - 1);
      exp_q.push_back(e);
      if (clr) for (int l = 0; l < COL; l++) mm[a][l] = 0;
    end

    lat = 0;
    idx = 0;
    got_done = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("acc_ready_drop", acc_ready, 0);
        chk("busy_flush", busy, 1);
      end
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (lat == 0 && out_valid) lat = c;
      if (lat != 0) idx++;
      if (mode == 4 && idx >= 5) break;
      @(posedge clk); #1;
      out_ready = (lat == 0) ? 1'b1 : rdy_pat(mode, idx);
    end
    @(posedge clk); #1;
    if (mode != 4) begin
      n_checks++;
      if (!got_done) begin
        n_fail++;
        $display("FAIL drain_done_timeout: actual no done required done within 400 cycles");
      end
      chk("drain_queue_empty", exp_q.size(), 0);
      out_ready = 1'b0;
    end else begin
      out_ready = 1'b0;
    end
    if (exp_lat > 0) chk("drain_latency", lat, exp_lat);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: pops the scoreboard on each handshake, checks done and stall hold
  // ---------------------------------------------------------------------------
  logic         prev_last_hs = 1'b0;
  logic         prev_stall   = 1'b0;
  logic [W-1:0] prev_data    = '0;
  logic         prev_last    = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      prev_last_hs = 1'b0;
      prev_stall   = 1'b0;
    end else begin
      chk("done_pulse", done, prev_last_hs);
      if (prev_stall) begin
        chk("stall_data_hold", out_data, prev_data);
        chk("stall_last_hold", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        $display("drain handshake: data=%h last=%0d", out_data, out_last);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_output: actual %h required no output", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", out_data, e.data);
          chk("out_last", out_last, e.last);
        end
      end
      prev_last_hs = out_valid && out_ready && out_last;
      prev_stall   = out_valid && !out_ready;
      prev_data    = out_data;
      prev_last    = out_last;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual simulation still running required finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int   na;
    int   len;
    logic wa;
    logic first;
    int   addr;

    reset       = 1'b0;
    acc_valid   = 1'b0;
    acc_first   = 1'b0;
    acc_addr    = '0;
    acc_data    = '0;
    drain_start = 1'b0;
    drain_base  = '0;
    drain_len   = '0;
    drain_relu  = 1'b0;
    drain_clr   = 1'b0;
    out_ready   = 1'b0;
    for (int a2 = 0; a2 < DEPTH; a2++)
      for (int l = 0; l < COL; l++) mm[a2][l] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Overwrite then add on one entry.
    set_all(5);  do_acc(1'b1, 3);
    set_all(-2); do_acc(1'b0, 3);
    acc_stop();
    drain(3, 1, 1'b0, 1'b0, 0, 1'b0, 2);

    // Same-address back-to-back adds exercise forwarding.
    set_all(0); do_acc(1'b1, 7);
    set_all(1);
    repeat (4) do_acc(1'b0, 7);
    acc_stop();
    drain(7, 1, 1'b0, 1'b0, 0, 1'b0, 2);

    // Drain window wrapping past the top entry with toggling ready.
    set_all(10); do_acc(1'b1, 62);
    set_all(20); do_acc(1'b1, 63);
    set_all(30); do_acc(1'b1, 0);
    set_all(40); do_acc(1'b1, 1);
    acc_stop();
    drain(62, 4, 1'b0, 1'b0, 1, 1'b0, 2);

    // ReLU with clear-on-read, then re-read the cleared entry.
    for (int i = 0; i < COL; i++) lv[i] = int'($urandom_range(0, 200)) - 100;
    lv[0] = -9;
    lv[1] = 9;
    do_acc(1'b1, 20);
    acc_stop();
    drain(20, 1, 1'b1, 1'b1, 0, 1'b0, 2);
    drain(20, 1, 1'b0, 1'b0, 0, 1'b0, 2);

    // Positive overflow.
    set_all(LMAX); do_acc(1'b1, 30);
    set_all(1);    do_acc(1'b0, 30);
    acc_stop();
    drain(30, 1, 1'b0, 1'b0, 0, 1'b0, 2);

    // Zero-length drain is ignored.
    drain(0, 0, 1'b0, 1'b0, 0, 1'b0, 0);

    // Accumulate accepted on the same edge as drain_start.
    set_all(3);
    set_acc(1'b1, 40);
    drain(40, 2, 1'b0, 1'b0, 0, 1'b1, 4);

    // Full-depth drain.
    drain(17, DEPTH, 1'b0, 1'b0, 2, 1'b0, 2);

    // Randomized accumulate bursts and drains.
    for (int r = 0; r < 25; r++) begin
      na = $urandom_range(1, 10);
      for (int k = 0; k < na; k++) begin
        for (int i = 0; i < COL; i++) lv[i] = int'($urandom_range(0, 65535)) + LMIN;
        first = ($urandom_range(0, 3) == 0);
        addr  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH-1);
        do_acc(first, addr);
        if ($urandom_range(0, 3) == 0) begin
          acc_valid = 1'b0;
          @(posedge clk); #1;
        end
      end
      len = ($urandom_range(0, 8) == 0) ? 0 : $urandom_range(1, DEPTH);
      wa  = (len != 0) && ($urandom_range(0, 1) == 1);
      if (wa) begin
        for (int i = 0; i < COL; i++) lv[i] = int'($urandom_range(0, 65535)) + LMIN;
        set_acc(1'($urandom_range(0, 1)), $urandom_range(0, DEPTH-1));
      end
      drain($urandom_range(0, DEPTH-1), len, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), $urandom_range(0, 2), wa, 0);
    end

    // drain_start one cycle after an add, then reset in the middle of the drain.
    set_all(100); do_acc(1'b1, 5);
    acc_stop();
    set_all(8);   do_acc(1'b0, 5);
    drain(5, 3, 1'b0, 1'b0, 4, 1'b0, 3);
    chk("mid_drain_valid", out_valid, 1);
    reset = 1'b0;
    exp_q.delete();
    for (int a2 = 0; a2 < DEPTH; a2++)
      for (int l = 0; l < COL; l++) mm[a2][l] = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    drain(5, 1, 1'b0, 1'b0, 0, 1'b0, 2);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_acc_buf.md
# psum_acc_buf

- Parametrised output-stationary partial-sum accumulation buffer for the PE array.
- Takes one `col`-lane psum vector per cycle and adds it, read-modify-write, into an internal `depth`-entry store. Back-to-back hazards are forwarded.
- Drains a programmable address window over a valid/ready stream, with optional ReLU and clear-on-read.
- Sits between the array output (`coreOut`-style bus) and the output SRAM. It replaces software-sequenced psum SRAM read/add/write.

## Interface
- `col`, 8, lanes per vector
- `psum_bw`, 16, signed bits per lane
- `depth`, 64, entries (power of two); `aw` = log2(`depth`)
- `clk` in 1: rising-edge clock
- `reset` in 1: asynchronous, active-low (0 = reset)
- `acc_valid` in 1: accumulate request
- `acc_ready` out 1: request accepted when `acc_valid && acc_ready`
- `acc_first` in 1: 1 = overwrite entry with `acc_data`; 0 = add to entry
- `acc_addr` in `aw`: target entry
- `acc_data` in `psum_bw*col`: lane i at bits [i*psum_bw +: psum_bw]
- `drain_start` in 1: start-drain pulse, sampled in IDLE only
- `drain_base` in `aw`: first entry to drain
- `drain_len` in `aw+1`: entries to drain, 0..`depth`
- `drain_relu` in 1: clamp negative lanes to 0 on output, captured at start
- `drain_clr` in 1: zero each entry after its handshake, captured at start
- `out_valid` out 1, `out_ready` in 1, `out_last` out 1: drain stream
- `out_data` out `psum_bw*col`: drained entry
- `done` out 1: one-cycle pulse after last drain handshake
- `busy` out 1: state != IDLE or pipeline non-empty

## Operation
- Store: `depth` x `psum_bw*col` register array. Async reset clears all entries and all outputs to 0.
- Accumulate pipeline, S1 → S2 → write:
  - S1 holds the accepted request.
  - S2 holds the request and the read value. Read value = S2-to-store forwarded sum if S2 is valid and its addr equals S1 addr; otherwise the store entry.
  - Write: entry = `acc_first` ? `acc_data` : read + `acc_data`, computed lane-wise, signed.
- Lane arithmetic: `psum_bw`-bit signed; overflow per Configuration.
- FSM states: IDLE, FLUSH, DRAIN.
- IDLE:
  - `acc_ready` = 1.
  - `drain_start` with `drain_len` = 0 is ignored.
  - `drain_start` with `drain_len` > 0 captures base, len, relu and clr, then goes to FLUSH.
  - An `acc_valid` in the same cycle is still accepted.
- FLUSH: `acc_ready` = 0. Stay until S1 and S2 are both empty, then go to DRAIN.
- DRAIN:
  - `acc_ready` = 0; `out_valid` = 1.
  - `out_data` = entry at ptr, ReLU applied if captured.
  - Each handshake advances ptr = (ptr+1) mod `depth`, wrapping past `depth`-1 to 0. If clr was captured, the handshaken entry is zeroed.
  - `out_last` = 1 on the final entry.
  - After the final handshake: go to IDLE and pulse `done`.
- `drain_start` outside IDLE is ignored.

## Timing
- Accumulate accepted at edge N: store updated at edge N+2; visible to a drain read from N+2.
- Throughput: 1 request/cycle with no stalls, including same-address back-to-back requests (forwarded).
- `drain_start` at edge N with an empty pipeline: FLUSH during cycle N+1; `out_valid` = 1 from cycle N+2.
- With a full pipeline, `out_valid` is delayed by at most 2 further cycles.
- With `out_ready` held high: one entry per cycle; `drain_len` entries take `drain_len` cycles.
- While `out_valid && !out_ready`: `out_data` and `out_last` are held stable.
- `done` is high for the cycle after the last handshake. `acc_ready` returns to 1 in that same cycle.
- `busy` is combinational from state and pipeline valids.
- Reset asserted mid-drain or mid-accumulate: immediate return to IDLE, store cleared, in-flight requests dropped, no `done`.

## Configuration
- `PSUM_ACC_SAT_EN` defined:
  - each lane add saturates to [-2^(psum_bw-1), 2^(psum_bw-1)-1];
  - overwrite (`acc_first`) is unaffected.
- Not defined: two's-complement wrap (modulo 2^psum_bw).

## Test plan
- Reset, then single accumulate: `acc_first`=1, addr 3, all lanes 5. Follow with addr 3, all lanes -2. Drain base 3, len 1 → `out_data` all lanes 3, `out_last`=1, `done` one cycle later.
- Same-address stream: 4 back-to-back adds of 1 to addr 7 after `acc_first` 0 → drain reads 4 per lane, proving forwarding.
- Wrap drain (`depth`=64):
  - entries 62, 63, 0, 1 set to 10, 20, 30, 40;
  - base 62, len 4, `out_ready` toggling 1,0,1,0 → values 10, 20, 30, 40 in order, stable during stalls;
  - `out_last` on 40.
- ReLU and clear: lane0 = -9, lane1 = 9. Drain with relu=1, clr=1 → out lanes 0 and 9. A second drain of the same entry gives 0 and 0.
- Overflow with `psum_bw`=16, entry 32767, add 1 → 32767 with `PSUM_ACC_SAT_EN`, -32768 without.
- `drain_start` issued one cycle after `acc_valid` to addr 5 (+8), drain base 5:
  - `acc_ready` drops;
  - drained value includes the +8;
  - `reset`=0 asserted mid-drain clears outputs to 0, and a later drain returns 0.
